// File: rtl/match_game_sequencer_if.sv
// Bundle of game-flow signals between the button/cursor/colour front-end
// (master) and the match game sequencer (slave).
interface match_game_sequencer_if;
   logic        start;
   logic        confirm;
   logic [2:0]  cursor;
   logic [15:0] colour_map;
   logic [3:0]  step;
   logic [2:0]  pick_a;
   logic [2:0]  pick_b;
   logic [7:0]  matched;
   logic        show_all;
   logic [2:0]  score;
   logic [3:0]  misses;
   logic        game_over;
   logic        win;

   modport master (
      output start, confirm, cursor, colour_map,
      input  step, pick_a, pick_b, matched, show_all, score, misses, game_over, win
   );

   modport slave (
      input  start, confirm, cursor, colour_map,
      output step, pick_a, pick_b, matched, show_all, score, misses, game_over, win
   );
endinterface

// File: rtl/match_game_sequencer.sv
// Game-flow controller for the 8-square colour-matching game: sequences
// preview, two picks per turn, compare and reveal, and tracks matched squares,
// score and misses until the game is won or lost.
module match_game_sequencer #(
   parameter int PREVIEW_CYCLES = 50000000,
   parameter int REVEAL_CYCLES  = 25000000,
   parameter int MAX_MISSES     = 6
) (
   input  logic                   clk25MHz,
   input  logic                   rst_n,
   match_game_sequencer_if.slave  game
);

   localparam int MAX_CYC = (PREVIEW_CYCLES > REVEAL_CYCLES) ? PREVIEW_CYCLES : REVEAL_CYCLES;
   localparam int TIMER_W = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
   localparam logic [TIMER_W-1:0] PREVIEW_LOAD = TIMER_W'(PREVIEW_CYCLES - 1);
   localparam logic [TIMER_W-1:0] REVEAL_LOAD  = TIMER_W'(REVEAL_CYCLES - 1);
   localparam logic [3:0]         MISS_LIMIT   = 4'(MAX_MISSES);

   // State encoding doubles as the step code seen by the cursor modules.
   typedef enum logic [3:0] {
      ST_IDLE    = 4'b0000,
      ST_PREVIEW = 4'b0001,
      ST_PICK_A  = 4'b0010,
      ST_PICK_B  = 4'b0011,
      ST_COMPARE = 4'b0100,
      ST_REVEAL  = 4'b0101,
      ST_WIN     = 4'b1110,
      ST_LOSE    = 4'b1111
   } state_t;

   state_t             state_r;
   logic [TIMER_W-1:0] timer_r;
   logic [2:0]         pick_a_r;
   logic [2:0]         pick_b_r;
   logic [7:0]         matched_r;
   logic               show_all_r;
   logic [2:0]         score_r;
   logic [3:0]         misses_r;
   logic               game_over_r;
   logic               win_r;

   logic [1:0]         start_sync_r;
   logic               start_prev_r;
   logic [1:0]         confirm_sync_r;
   logic               confirm_prev_r;

   logic               start_p_s;
   logic               confirm_p_s;
   logic               colours_equal_s;
   logic               cursor_free_s;

   // Colour of one square out of the packed 2-bit-per-square map.
   function automatic logic [1:0] colour_of(input logic [15:0] map, input logic [2:0] sq);
      return map[{sq, 1'b0} +: 2];
   endfunction

   // Two-flop synchronisers plus previous-value flops for edge detection.
   always_ff @(posedge clk25MHz or negedge rst_n) begin
      if (!rst_n) begin
         start_sync_r   <= 2'b00;
         start_prev_r   <= 1'b0;
         confirm_sync_r <= 2'b00;
         confirm_prev_r <= 1'b0;
      end else begin
         start_sync_r   <= {start_sync_r[0], game.start};
         start_prev_r   <= start_sync_r[1];
         confirm_sync_r <= {confirm_sync_r[0], game.confirm};
         confirm_prev_r <= confirm_sync_r[1];
      end
   end

   // One-cycle button pulses and pick/compare qualifiers.
   always_comb begin
      start_p_s       = start_sync_r[1] & ~start_prev_r;
      confirm_p_s     = confirm_sync_r[1] & ~confirm_prev_r;
      colours_equal_s = (colour_of(game.colour_map, pick_a_r) == colour_of(game.colour_map, pick_b_r));
      cursor_free_s   = ~matched_r[game.cursor];
   end

   // Game FSM with all outputs registered alongside the state.
   always_ff @(posedge clk25MHz or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         timer_r     <= '0;
         pick_a_r    <= 3'd0;
         pick_b_r    <= 3'd0;
         matched_r   <= 8'd0;
         show_all_r  <= 1'b0;
         score_r     <= 3'd0;
         misses_r    <= 4'd0;
         game_over_r <= 1'b0;
         win_r       <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE, ST_WIN, ST_LOSE: begin
               // A new game starts the same way from idle or a finished game.
               if (start_p_s) begin
                  state_r     <= ST_PREVIEW;
                  timer_r     <= PREVIEW_LOAD;
                  pick_a_r    <= 3'd0;
                  pick_b_r    <= 3'd0;
                  matched_r   <= 8'd0;
                  score_r     <= 3'd0;
                  misses_r    <= 4'd0;
                  show_all_r  <= 1'b1;
                  game_over_r <= 1'b0;
                  win_r       <= 1'b0;
               end else begin
                  state_r <= state_r;
               end
            end
            ST_PREVIEW: begin
               if (timer_r == '0) begin
                  state_r    <= ST_PICK_A;
                  show_all_r <= 1'b0;
               end else begin
                  timer_r <= timer_r - 1'b1;
               end
            end
            ST_PICK_A: begin
               if (confirm_p_s && cursor_free_s) begin
                  pick_a_r <= game.cursor;
                  state_r  <= ST_PICK_B;
               end else begin
                  state_r <= ST_PICK_A;
               end
            end
            ST_PICK_B: begin
               if (confirm_p_s && cursor_free_s && (game.cursor != pick_a_r)) begin
                  pick_b_r <= game.cursor;
                  state_r  <= ST_COMPARE;
               end else begin
                  state_r <= ST_PICK_B;
               end
            end
            ST_COMPARE: begin
               if (colours_equal_s) begin
                  matched_r <= matched_r | (8'd1 << pick_a_r) | (8'd1 << pick_b_r);
                  score_r   <= score_r + 3'd1;
               end else begin
                  misses_r  <= (misses_r == 4'd15) ? 4'd15 : (misses_r + 4'd1);
               end
               timer_r <= REVEAL_LOAD;
               state_r <= ST_REVEAL;
            end
            ST_REVEAL: begin
               // Score and misses were updated in COMPARE, so they are final here.
               if (timer_r != '0) begin
                  timer_r <= timer_r - 1'b1;
               end else if (score_r == 3'd4) begin
                  state_r     <= ST_WIN;
                  game_over_r <= 1'b1;
                  win_r       <= 1'b1;
               end else if (misses_r >= MISS_LIMIT) begin
                  state_r     <= ST_LOSE;
                  game_over_r <= 1'b1;
                  win_r       <= 1'b0;
               end else begin
                  state_r <= ST_PICK_A;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               show_all_r  <= 1'b0;
               game_over_r <= 1'b0;
               win_r       <= 1'b0;
            end
         endcase
      end
   end

   // Registered values driven onto the interface.
   always_comb begin
      game.step      = state_r;
      game.pick_a    = pick_a_r;
      game.pick_b    = pick_b_r;
      game.matched   = matched_r;
      game.show_all  = show_all_r;
      game.score     = score_r;
      game.misses    = misses_r;
      game.game_over = game_over_r;
      game.win       = win_r;
   end

endmodule

// File: tb/tb_match_game_sequencer.sv
// Self-checking bench for match_game_sequencer: directed game scenarios plus
// randomized games, all checked against a turn-level model of the game rules.
module tb_match_game_sequencer;
   localparam int P  = 8;
   localparam int R  = 4;
   localparam int MM = 2;

   logic clk25MHz = 1'b0;
   logic rst_n    = 1'b0;
   always #20 clk25MHz = ~clk25MHz;

   match_game_sequencer_if gif();

   match_game_sequencer #(
      .PREVIEW_CYCLES(P),
      .REVEAL_CYCLES(R),
      .MAX_MISSES(MM)
   ) dut (
      .clk25MHz(clk25MHz),
      .rst_n(rst_n),
      .game(gif)
   );

   int err_cnt = 0;
   int chk_cnt = 0;

   // Model of the game as the player sees it.
   int m_step, m_pa, m_pb, m_matched, m_score, m_misses, m_map;

   task automatic chk(input string tag, input logic [31:0] obs, input int exp);
      chk_cnt++;
      if (obs !== 32'(exp)) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk25MHz);
      #1;
   endtask

   function automatic int colour(input int sq);
      return (m_map >> (2 * sq)) & 3;
   endfunction

   function automatic bit is_matched(input int sq);
      return ((m_matched >> sq) & 1) != 0;
   endfunction

   task automatic model_reset();
      m_step = 0; m_pa = 0; m_pb = 0; m_matched = 0; m_score = 0; m_misses = 0;
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".step"},      gif.step,      m_step);
      chk({tag, ".pick_a"},    gif.pick_a,    m_pa);
      chk({tag, ".pick_b"},    gif.pick_b,    m_pb);
      chk({tag, ".matched"},   gif.matched,   m_matched);
      chk({tag, ".score"},     gif.score,     m_score);
      chk({tag, ".misses"},    gif.misses,    m_misses);
      chk({tag, ".show_all"},  gif.show_all,  (m_step == 1) ? 1 : 0);
      chk({tag, ".game_over"}, gif.game_over, (m_step >= 14) ? 1 : 0);
      chk({tag, ".win"},       gif.win,       (m_step == 14) ? 1 : 0);
   endtask

   task automatic do_start();
      int h;
      int shown;
      bit accept;
      h      = $urandom_range(1, 3);
      accept = (m_step == 0) || (m_step == 14) || (m_step == 15);
      gif.start = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         tick();
         if (i == h) gif.start = 1'b0;
         if (i == 2) chk("start.latency", gif.step, m_step);
      end
      if (accept) begin
         model_reset();
         m_step = 1;
         chk_all("start");
         shown = gif.show_all;
         for (int i = 1; i < P; i++) begin
            tick();
            shown += gif.show_all;
         end
         tick();
         m_step = 2;
         chk("preview_len", shown, P);
         chk_all("after_preview");
      end else begin
         repeat (3) tick();
         chk_all("start_ignored");
      end
   endtask

   task automatic confirm_on(input int sq);
      int h;
      int free_sq;
      bit took_a, took_b;
      took_a = (m_step == 2) && !is_matched(sq);
      took_b = (m_step == 3) && !is_matched(sq) && (sq != m_pa);
      h = $urandom_range(1, 3);
      gif.cursor  = 3'(sq);
      gif.confirm = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         tick();
         if (i == h) gif.confirm = 1'b0;
         if (i == 2) chk("confirm.latency", gif.step, m_step);
      end
      if (took_a) begin
         m_pa = sq;
         m_step = 3;
         chk_all("pick_a");
      end else if (took_b) begin
         m_pb = sq;
         m_step = 4;
         chk_all("pick_b");
         tick();
         if (colour(m_pa) == colour(m_pb)) begin
            m_matched = m_matched | (1 << m_pa) | (1 << m_pb);
            m_score++;
         end else begin
            m_misses = (m_misses >= 15) ? 15 : m_misses + 1;
         end
         m_step = 5;
         chk_all("compare");
         // A confirm during reveal, aimed at a free square, must be dropped.
         free_sq = 0;
         for (int s = 7; s >= 0; s--) if (!is_matched(s)) free_sq = s;
         gif.cursor  = 3'(free_sq);
         gif.confirm = 1'b1;
         for (int i = 1; i < R; i++) begin
            tick();
            if (i == 1) gif.confirm = 1'b0;
         end
         chk_all("reveal_hold");
         tick();
         if (m_score == 4)        m_step = 14;
         else if (m_misses >= MM) m_step = 15;
         else                     m_step = 2;
         chk_all("reveal_end");
      end else begin
         chk_all("confirm_ignored");
      end
      repeat (3) tick();
      chk_all("settle");
   endtask

   initial begin
      int cols[8];
      int j, tmp, turns;
      gif.start = 1'b0;
      gif.confirm = 1'b0;
      gif.cursor = 3'd0;
      gif.colour_map = 16'h0000;
      model_reset();
      m_map = 0;
      repeat (3) tick();
      chk_all("reset");
      rst_n = 1'b1;
      tick();

      // Directed game: mismatch, match, illegal confirms, then loss.
      m_map = 32'h55AA;
      gif.colour_map = 16'h55AA;
      do_start();
      confirm_on(0); confirm_on(4);
      confirm_on(0); confirm_on(1);
      confirm_on(0);
      confirm_on(2);
      confirm_on(2);
      confirm_on(1);
      // Held confirm: one pulse only, even when the cursor moves to a legal square.
      gif.cursor = 3'd2;
      gif.confirm = 1'b1;
      repeat (4) tick();
      chk_all("held_on_pick_a");
      gif.cursor = 3'd5;
      repeat (6) tick();
      chk_all("held_level");
      gif.confirm = 1'b0;
      repeat (3) tick();
      confirm_on(4);
      confirm_on(3);
      do_start();
      do_start();

      // Directed winning game.
      confirm_on(0); confirm_on(1);
      confirm_on(2); confirm_on(3);
      confirm_on(4); confirm_on(5);
      confirm_on(6); confirm_on(7);
      chk("win.score", gif.score, 4);
      chk("win.matched", gif.matched, 8'hFF);

      // Reset in the middle of a reveal clears everything at once.
      do_start();
      confirm_on(6);
      gif.cursor = 3'd7;
      gif.confirm = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         if (i == 1) gif.confirm = 1'b0;
      end
      chk("pre_reset.step", gif.step, 5);
      #5 rst_n = 1'b0;
      #1;
      model_reset();
      chk_all("async_reset");
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      chk_all("after_reset");

      // Randomized games on shuffled pair layouts with random cursor picks.
      for (int g = 0; g < 6; g++) begin
         cols = '{0, 0, 1, 1, 2, 2, 3, 3};
         for (int i = 7; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = cols[i]; cols[i] = cols[j]; cols[j] = tmp;
         end
         m_map = 0;
         for (int i = 0; i < 8; i++) m_map = m_map | (cols[i] << (2 * i));
         gif.colour_map = 16'(m_map);
         do_start();
         turns = 0;
         while ((m_step != 14) && (m_step != 15) && (turns < 40)) begin
            confirm_on($urandom_range(0, 7));
            turns++;
         end
      end

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end
endmodule
